// File: rtl/io_input_conditioner_if.sv
// Bundle between the input conditioner and the io block: debounced levels,
// press flags and the 4-phase flag-clear handshake.
interface io_input_conditioner_if #(
    parameter int NUM_BTN = 4,
    parameter int NUM_SW  = 16
);
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_SW-1:0]  sw_level;
    logic [NUM_BTN-1:0] btn_press_pulse;
    logic [NUM_BTN-1:0] btn_event;
    logic               clr_req;
    logic [NUM_BTN-1:0] clr_mask;
    logic               clr_ack;

    // io side
    modport master (
        input  btn_level, sw_level, btn_press_pulse, btn_event, clr_ack,
        output clr_req, clr_mask
    );

    // conditioner side
    modport slave (
        output btn_level, sw_level, btn_press_pulse, btn_event, clr_ack,
        input  clr_req, clr_mask
    );
endinterface

// File: rtl/io_input_conditioner.sv
// Synchronises, debounces and edge-detects raw buttons/switches; keeps sticky
// press flags that io clears through a req/ack handshake.
module io_input_conditioner #(
    parameter int TICK_CYCLES  = 100000,
    parameter int STABLE_TICKS = 10,
    parameter int NUM_BTN      = 4,
    parameter int NUM_SW       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_SW-1:0]  sw_raw,
    io_input_conditioner_if.slave io
);
    localparam int NUM_IN = NUM_BTN + NUM_SW;
    localparam int PRE_W  = $clog2(TICK_CYCLES);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
    localparam logic [3:0]       CNT_LAST = 4'(STABLE_TICKS - 1);

    typedef enum logic {IDLE, ACK} state_t;

    logic [NUM_IN-1:0]  raw, s1, s2, level;
    logic [3:0]         cnt [NUM_IN];
    logic [PRE_W-1:0]   pre_cnt;
    logic               tick;
    logic [NUM_BTN-1:0] btn_done, btn_rise, pulse, evt;
    state_t             state, state_nxt;
    logic               clear_en;

    assign raw = {sw_raw, btn_raw};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 1'b1;
    end

    // A single agreeing sample clears the run, so short bounces never qualify.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
            for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (s2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= s2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        btn_done = '0;
        for (int i = 0; i < NUM_BTN; i++) btn_done[i] = (cnt[i] == CNT_LAST);
    end

    // Pulse is registered on the same edge that raises the debounced level.
    assign btn_rise = {NUM_BTN{tick}} & s2[NUM_BTN-1:0] & ~level[NUM_BTN-1:0] & btn_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pulse <= '0;
        else      pulse <= btn_rise;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clear_en  = 1'b0;
        case (state)
            IDLE: if (io.clr_req) begin
                state_nxt = ACK;
                clear_en  = 1'b1;
            end
            ACK:  if (!io.clr_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // OR-ing the pulse after the clear lets a coincident press win.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) evt <= '0;
        else      evt <= (evt & ~(clear_en ? io.clr_mask : '0)) | pulse;
    end

    assign io.btn_level       = level[NUM_BTN-1:0];
    assign io.sw_level        = level[NUM_IN-1:NUM_BTN];
    assign io.btn_press_pulse = pulse;
    assign io.btn_event       = evt;
    assign io.clr_ack         = (state == ACK);
endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboarded bench for io_input_conditioner: a cycle reference model queues
// expected outputs, a monitor compares them; directed scenarios add targeted checks.
module tb_io_input_conditioner;
    localparam int T  = 4;
    localparam int ST = 3;
    localparam int NB = 4;
    localparam int NS = 16;
    localparam int NI = NB + NS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NS-1:0] sw_raw = '0;

    io_input_conditioner_if #(.NUM_BTN(NB), .NUM_SW(NS)) bus ();

    io_input_conditioner #(
        .TICK_CYCLES(T), .STABLE_TICKS(ST), .NUM_BTN(NB), .NUM_SW(NS)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw), .io(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NB-1:0] bl;
        logic [NS-1:0] sl;
        logic [NB-1:0] bp;
        logic [NB-1:0] be;
        logic          ack;
    } snap_t;

    snap_t q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model state
    bit [NI-1:0] dly[$];
    bit [NI-1:0] synced;
    bit          mtick;
    int          mcyc;
    int          mcnt [NI];
    bit [NI-1:0] mlvl;
    bit [NB-1:0] mpulse, mev, newpulse;
    bit          mack;

    task automatic model_reset();
        dly.delete();
        dly.push_back('0);
        dly.push_back('0);
        mcyc   = 0;
        foreach (mcnt[i]) mcnt[i] = 0;
        mlvl   = '0;
        mpulse = '0;
        mev    = '0;
        mack   = 1'b0;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (!rst) begin
            model_reset();
        end else begin
            synced = dly.pop_front();
            dly.push_back({sw_raw, btn_raw});
            mtick = (mcyc % T) == (T - 1);
            mcyc++;
            if (!mack && bus.clr_req) mev = mev & ~bus.clr_mask;
            mev  = mev | mpulse;
            mack = bus.clr_req;
            newpulse = '0;
            if (mtick) begin
                for (int i = 0; i < NI; i++) begin
                    if (synced[i] == mlvl[i]) begin
                        mcnt[i] = 0;
                    end else if (mcnt[i] == ST - 1) begin
                        mlvl[i] = synced[i];
                        mcnt[i] = 0;
                        if (i < NB && synced[i]) newpulse[i] = 1'b1;
                    end else begin
                        mcnt[i] = mcnt[i] + 1;
                    end
                end
            end
            mpulse = newpulse;
        end
        q.push_back({mlvl[NB-1:0], mlvl[NI-1:NB], mpulse, mev, mack});
    end

    always @(negedge rst) begin
        model_reset();
        foreach (q[i]) q[i] = '0;
    end

    snap_t exp_s, got_s;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_s = q.pop_front();
            got_s = {bus.btn_level, bus.sw_level, bus.btn_press_pulse, bus.btn_event, bus.clr_ack};
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL cycle_model t=%0t got bl=%h sl=%h bp=%h be=%h ack=%b expected bl=%h sl=%h bp=%h be=%h ack=%b",
                         $time, got_s.bl, got_s.sl, got_s.bp, got_s.be, got_s.ack,
                         exp_s.bl, exp_s.sl, exp_s.bp, exp_s.be, exp_s.ack);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] all_out();
        return 32'({bus.btn_level, bus.sw_level, bus.btn_press_pulse, bus.btn_event, bus.clr_ack});
    endfunction

    initial begin
        int  lat, npulse;
        bit  found, bad, ok, hit;
        logic [NB-1:0] pv;

        bus.clr_req  = 1'b0;
        bus.clr_mask = '0;
        step(3);
        rst = 1'b1;

        // Reset mid-operation with flags set and a debounce run in progress
        btn_raw = 4'b1010;
        step(20);
        btn_raw = '0;
        step(20);
        check("pre_reset_event", 32'(bus.btn_event), 32'(4'b1010));
        sw_raw = 16'h0001;
        step(6);
        rst = 1'b0;
        #1;
        check("reset_outputs", all_out(), 32'd0);
        sw_raw = 16'hA5C3;
        step(3);
        rst = 1'b1;
        step(15);
        check("reset_sw_level", 32'(bus.sw_level), 32'(16'hA5C3));
        check("reset_no_event", 32'(bus.btn_event), 32'd0);

        // Bounce rejection
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            btn_raw[0] = ((k / 3) % 2) == 0;
            step(1);
            bad |= bus.btn_level[0] | bus.btn_press_pulse[0] | bus.btn_event[0];
        end
        btn_raw[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            bad |= bus.btn_level[0] | bus.btn_press_pulse[0] | bus.btn_event[0];
        end
        check("bounce_reject", 32'(bad), 32'd0);

        // Clean press
        btn_raw[2] = 1'b1;
        found = 1'b0; lat = 0; npulse = 0; pv = '0;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            if (!found && bus.btn_level[2]) begin
                found = 1'b1;
                lat   = k;
            end
            if (bus.btn_press_pulse != '0) begin
                npulse++;
                pv = bus.btn_press_pulse;
            end
        end
        check("press_latency_ok", 32'(found && lat >= 11 && lat <= 15), 32'd1);
        check("press_pulse_count", 32'(npulse), 32'd1);
        check("press_pulse_value", 32'(pv), 32'(4'b0100));
        btn_raw[2] = 1'b0;
        step(20);
        check("press_sticky", 32'(bus.btn_event), 32'(4'b0100));

        // Handshake clear
        btn_raw[1] = 1'b1;
        step(20);
        btn_raw[1] = 1'b0;
        step(20);
        check("hs_pre_event", 32'(bus.btn_event), 32'(4'b0110));
        bus.clr_mask = 4'b0010;
        bus.clr_req  = 1'b1;
        step(1);
        check("hs_clear", 32'(bus.btn_event), 32'(4'b0100));
        check("hs_ack_rise", 32'(bus.clr_ack), 32'd1);
        ok = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step(1);
            ok &= (bus.clr_ack == 1'b1) && (bus.btn_event == 4'b0100);
        end
        check("hs_hold_one_clear", 32'(ok), 32'd1);
        bus.clr_req = 1'b0;
        check("hs_ack_before_drop", 32'(bus.clr_ack), 32'd1);
        step(1);
        check("hs_ack_drop", 32'(bus.clr_ack), 32'd0);
        bus.clr_mask = '0;
        step(2);

        // Set-wins: raise req during the pulse cycle
        btn_raw[0] = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (mpulse[0]) begin
                bus.clr_mask = 4'b0001;
                bus.clr_req  = 1'b1;
                hit = 1'b1;
                break;
            end
        end
        check("collide_timing", 32'(hit), 32'd1);
        step(1);
        check("set_wins", 32'(bus.btn_event[0]), 32'd1);
        check("collide_ack", 32'(bus.clr_ack), 32'd1);
        bus.clr_req = 1'b0;
        step(1);
        bus.clr_mask = '0;
        btn_raw[0] = 1'b0;
        step(20);

        // Simultaneous inputs
        btn_raw = 4'hF;
        sw_raw  = 16'hFFFF;
        found   = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (!found && bus.btn_level != '0) begin
                found = 1'b1;
                check("multi_btn_level", 32'(bus.btn_level), 32'hF);
                check("multi_sw_level", 32'(bus.sw_level), 32'hFFFF);
                check("multi_pulse", 32'(bus.btn_press_pulse), 32'hF);
            end
        end
        check("multi_seen", 32'(found), 32'd1);
        check("multi_event", 32'(bus.btn_event), 32'hF);

        // Randomized traffic, including one asynchronous reset
        btn_raw = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            step(1);
            if ($urandom_range(0, 15) == 0) btn_raw ^= 4'($urandom());
            if ($urandom_range(0, 19) == 0) sw_raw  ^= 16'($urandom());
            if (!bus.clr_req) begin
                if ($urandom_range(0, 9) == 0) begin
                    bus.clr_mask = 4'($urandom());
                    bus.clr_req  = 1'b1;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                bus.clr_req = 1'b0;
            end
            if (cyc == 1000) begin
                rst = 1'b0;
                #1;
                check("rand_reset_outputs", all_out(), 32'd0);
                step(2);
                rst = 1'b1;
            end
        end
        bus.clr_req = 1'b0;
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
